// File: rtl/io_pwm.sv
// Three-channel PWM on the IO bus: prescaled period counter, shadowed PERIOD/DUTY registers
// and a one-stage pipelined read that joins the daisy-chained read-data path.
module io_pwm #(
  parameter logic [13:0] PWM_BASE = 14'h3E00,
  parameter int unsigned NCH      = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           dma_io_we,
  input  logic [13:0]    dma_io_wadr,
  input  logic [31:0]    dma_io_wdata,
  input  logic [13:0]    dma_io_radr,
  input  logic           dma_io_radr_en,
  input  logic [31:0]    dma_io_rdata_in,
  output logic [31:0]    dma_io_rdata,
  output logic [NCH-1:0] pwm_out,
  output logic           pwm_wrap
);

  logic           en_q, en_d;
  logic           inv_q, inv_d;
  logic [3:0]     presc_q, presc_d;
  logic [15:0]    period_sh_q, period_sh_d;
  logic [15:0]    period_act_q, period_act_d;
  logic [15:0]    duty_sh_q  [NCH];
  logic [15:0]    duty_sh_d  [NCH];
  logic [15:0]    duty_act_q [NCH];
  logic [15:0]    duty_act_d [NCH];
  logic           pend_q, pend_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [3:0]     pre_q, pre_d;
  logic [NCH-1:0] pwm_q, pwm_d;
  logic           wrap_q, wrap_d;
  logic           rd_hit_q, rd_hit_d;
  logic [31:0]    rd_val_q, rd_val_d;

  logic [13:0]    woff, roff;
  logic           wr_ctrl, wr_period, wr_shadow;
  logic [NCH-1:0] wr_duty;
  logic           tick, wrap_tick, copy;
  logic           unused_wdata;

  assign woff         = dma_io_wadr - PWM_BASE;
  assign roff         = dma_io_radr - PWM_BASE;
  assign unused_wdata = ^dma_io_wdata[31:16];

  always_comb begin
    wr_ctrl   = dma_io_we && (woff == 14'd0);
    wr_period = dma_io_we && (woff == 14'd1);
    wr_shadow = wr_period;
    for (int i = 0; i < int'(NCH); i++) begin
      wr_duty[i] = dma_io_we && (woff == 14'(i + 2));
      wr_shadow  = wr_shadow | wr_duty[i];
    end
  end

  assign tick      = en_q && (pre_q == presc_q);
  assign wrap_tick = tick && (cnt_q == period_act_q);
  // While disabled the actives track the shadows every cycle.
  assign copy      = !en_q || wrap_tick;

  always_comb begin
    en_d         = wr_ctrl ? dma_io_wdata[0]   : en_q;
    inv_d        = wr_ctrl ? dma_io_wdata[1]   : inv_q;
    presc_d      = wr_ctrl ? dma_io_wdata[7:4] : presc_q;
    period_sh_d  = wr_period ? dma_io_wdata[15:0] : period_sh_q;
    period_act_d = copy ? period_sh_q : period_act_q;
    for (int i = 0; i < int'(NCH); i++) begin
      duty_sh_d[i]  = wr_duty[i] ? dma_io_wdata[15:0] : duty_sh_q[i];
      duty_act_d[i] = copy ? duty_sh_q[i] : duty_act_q[i];
    end

    if (wr_shadow)  pend_d = 1'b1;
    else if (copy)  pend_d = 1'b0;
    else            pend_d = pend_q;

    // An out-of-range count after a PRESC shrink restarts without ticking.
    pre_d = (!en_q || (pre_q >= presc_q)) ? 4'd0 : pre_q + 4'd1;

    if (!en_q || wrap_tick) cnt_d = 16'd0;
    else if (tick)          cnt_d = cnt_q + 16'd1;
    else                    cnt_d = cnt_q;

    for (int i = 0; i < int'(NCH); i++) begin
      pwm_d[i] = en_q ? ((cnt_q < duty_act_q[i]) ^ inv_q) : inv_q;
    end
    wrap_d = wrap_tick;
  end

  always_comb begin
    rd_hit_d = dma_io_radr_en && (roff < 14'(NCH + 3));
    rd_val_d = 32'd0;
    if (roff == 14'd0) rd_val_d = {24'd0, presc_q, 2'b00, inv_q, en_q};
    if (roff == 14'd1) rd_val_d = {16'd0, period_sh_q};
    for (int i = 0; i < int'(NCH); i++) begin
      if (roff == 14'(i + 2)) rd_val_d = {16'd0, duty_sh_q[i]};
    end
    if (roff == 14'(NCH + 2)) rd_val_d = {cnt_q, 15'd0, pend_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= 1'b0;
      inv_q        <= 1'b0;
      presc_q      <= 4'd0;
      period_sh_q  <= 16'hFFFF;
      period_act_q <= 16'hFFFF;
      for (int i = 0; i < int'(NCH); i++) begin
        duty_sh_q[i]  <= 16'd0;
        duty_act_q[i] <= 16'd0;
      end
      pend_q   <= 1'b0;
      cnt_q    <= 16'd0;
      pre_q    <= 4'd0;
      pwm_q    <= '0;
      wrap_q   <= 1'b0;
      rd_hit_q <= 1'b0;
      rd_val_q <= 32'd0;
    end else begin
      en_q         <= en_d;
      inv_q        <= inv_d;
      presc_q      <= presc_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      for (int i = 0; i < int'(NCH); i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      pwm_q    <= pwm_d;
      wrap_q   <= wrap_d;
      rd_hit_q <= rd_hit_d;
      rd_val_q <= rd_val_d;
    end
  end

  assign dma_io_rdata = rd_hit_q ? rd_val_q : dma_io_rdata_in;
  assign pwm_out      = pwm_q;
  assign pwm_wrap     = wrap_q;

endmodule

// File: tb/tb_io_pwm.sv
// Scoreboard bench for io_pwm: expectations are queued with the stimulus and popped when the
// matching read data, waveform window or status sample comes back.
module tb_io_pwm;

  localparam logic [13:0] BASE   = 14'h3E00;
  localparam logic [13:0] A_CTRL = BASE;
  localparam logic [13:0] A_PER  = BASE + 14'd1;
  localparam logic [13:0] A_D0   = BASE + 14'd2;
  localparam logic [13:0] A_D1   = BASE + 14'd3;
  localparam logic [13:0] A_D2   = BASE + 14'd4;
  localparam logic [13:0] A_ST   = BASE + 14'd5;
  localparam logic [13:0] A_BAD  = BASE + 14'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dma_io_we = 1'b0;
  logic [13:0] dma_io_wadr = '0;
  logic [31:0] dma_io_wdata = '0;
  logic [13:0] dma_io_radr = '0;
  logic        dma_io_radr_en = 1'b0;
  logic [31:0] dma_io_rdata_in = 32'hA5A5_0001;
  logic [31:0] dma_io_rdata;
  logic [2:0]  pwm_out;
  logic        pwm_wrap;

  int tests_run = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  io_pwm #(.PWM_BASE(BASE), .NCH(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .dma_io_we      (dma_io_we),
    .dma_io_wadr    (dma_io_wadr),
    .dma_io_wdata   (dma_io_wdata),
    .dma_io_radr    (dma_io_radr),
    .dma_io_radr_en (dma_io_radr_en),
    .dma_io_rdata_in(dma_io_rdata_in),
    .dma_io_rdata   (dma_io_rdata),
    .pwm_out        (pwm_out),
    .pwm_wrap       (pwm_wrap)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dma_io_we = 1'b0;
    dma_io_radr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    dma_io_we = 1'b1;
    dma_io_wadr = a;
    dma_io_wdata = d;
    @(negedge clk);
    dma_io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] a, input logic [31:0] e, input logic [31:0] mask,
                          input string name);
    logic [31:0] got, want;
    @(negedge clk);
    dma_io_radr_en = 1'b1;
    dma_io_radr = a;
    exp_q.push_back(e & mask);
    @(negedge clk);
    dma_io_radr_en = 1'b0;
    got = dma_io_rdata & mask;
    want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic wait_wrap(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (pwm_wrap) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++;
      fails++;
      $display("FAIL %s: no pwm_wrap within 200 cycles, expected one", name);
    end
  endtask

  // Starting at a wrap sample, observe one period of len cycles on channel ch, optionally
  // writing (wa, wd) at sample wr_at and reading STATUS at sample rd_at.
  task automatic measure_period(input int len, input int ch, input int wr_at,
                                input logic [13:0] wa, input logic [31:0] wd, input int rd_at,
                                output int hi, output bit wrap_ok, output bit pend);
    hi = 0;
    wrap_ok = 1'b1;
    pend = 1'b0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (i == wr_at + 1) dma_io_we = 1'b0;
      if (i == rd_at + 1) begin
        pend = dma_io_rdata[0];
        dma_io_radr_en = 1'b0;
      end
      if (pwm_out[ch]) hi++;
      if (pwm_wrap != (i == len)) wrap_ok = 1'b0;
      if (i == wr_at) begin
        dma_io_we = 1'b1;
        dma_io_wadr = wa;
        dma_io_wdata = wd;
      end
      if (i == rd_at) begin
        dma_io_radr_en = 1'b1;
        dma_io_radr = A_ST;
      end
    end
  endtask

  task automatic check_period(input int len, input int ch, input int exp_hi, input int wr_at,
                              input logic [13:0] wa, input logic [31:0] wd, input int rd_at,
                              input bit exp_pend, input string name);
    int hi;
    bit wrap_ok, pend;
    exp_q.push_back(32'(exp_hi));
    exp_q.push_back(32'd1);
    if (rd_at > 0) exp_q.push_back({31'd0, exp_pend});
    measure_period(len, ch, wr_at, wa, wd, rd_at, hi, wrap_ok, pend);
    tests_run++;
    if (32'(hi) !== exp_q[0]) begin
      fails++;
      $display("FAIL %s high cycles: got %0d expected %0d", name, hi, exp_q[0]);
    end
    void'(exp_q.pop_front());
    tests_run++;
    if ({31'd0, wrap_ok} !== exp_q[0]) begin
      fails++;
      $display("FAIL %s wrap spacing: got ok=%0d expected one pulse at cycle %0d", name,
               wrap_ok, len);
    end
    void'(exp_q.pop_front());
    if (rd_at > 0) begin
      tests_run++;
      if ({31'd0, pend} !== exp_q[0]) begin
        fails++;
        $display("FAIL %s pend: got %0d expected %0d", name, pend, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (pwm_out !== 3'b000 || pwm_wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset outputs: got %b/%b expected 000/0", pwm_out, pwm_wrap);
    end
    tests_run++;
    if (dma_io_rdata !== dma_io_rdata_in) begin
      fails++;
      $display("FAIL reset passthrough: got %h expected %h", dma_io_rdata, dma_io_rdata_in);
    end
    bus_read(A_CTRL, 32'h0, 32'hFFFF_FFFF, "reset ctrl");
    bus_read(A_PER, 32'h0000_FFFF, 32'hFFFF_FFFF, "reset period");
    bus_read(A_D0, 32'h0, 32'hFFFF_FFFF, "reset duty0");
    bus_read(A_D2, 32'h0, 32'hFFFF_FFFF, "reset duty2");
    bus_read(A_ST, 32'h0, 32'hFFFF_FFFF, "reset status");
  endtask

  task automatic test_basic();
    do_reset();
    bus_write(A_PER, 32'd9);
    bus_write(A_D0, 32'd3);
    bus_write(A_CTRL, 32'h01);
    wait_wrap("basic first wrap");
    for (int p = 0; p < 3; p++) check_period(10, 0, 3, 0, A_CTRL, 0, 0, 1'b0, "basic period");
  endtask

  task automatic test_presc();
    logic [31:0] seen = '0;
    logic [15:0] c, maxc = '0;
    do_reset();
    bus_write(A_CTRL, 32'h30);
    bus_write(A_PER, 32'd4);
    bus_write(A_D1, 32'd5);
    bus_write(A_CTRL, 32'h31);
    wait_wrap("presc first wrap");
    check_period(20, 1, 20, 0, A_CTRL, 0, 0, 1'b0, "presc ch1");
    check_period(20, 0, 0, 0, A_CTRL, 0, 0, 1'b0, "presc ch0");
    exp_q.push_back(32'h1F);
    exp_q.push_back(32'd4);
    @(negedge clk);
    dma_io_radr_en = 1'b1;
    dma_io_radr = A_ST;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c = dma_io_rdata[31:16];
      if (c < 16'd32) seen[c[4:0]] = 1'b1;
      if (c > maxc) maxc = c;
    end
    dma_io_radr_en = 1'b0;
    tests_run++;
    if (seen !== exp_q[0]) begin
      fails++;
      $display("FAIL presc cnt values: got %h expected %h", seen, exp_q[0]);
    end
    void'(exp_q.pop_front());
    tests_run++;
    if ({16'd0, maxc} !== exp_q[0]) begin
      fails++;
      $display("FAIL presc cnt max: got %0d expected %0d", maxc, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_shadow();
    do_reset();
    bus_write(A_PER, 32'd9);
    bus_write(A_D0, 32'd3);
    bus_write(A_CTRL, 32'h01);
    wait_wrap("shadow first wrap");
    check_period(10, 0, 3, 2, A_D0, 32'd7, 4, 1'b1, "shadow old duty");
    check_period(10, 0, 7, 0, A_CTRL, 0, 0, 1'b0, "shadow new duty");
    bus_read(A_ST, 32'h0, 32'h1, "shadow pend cleared");
    bus_read(A_D0, 32'd7, 32'hFFFF_FFFF, "shadow duty0 readback");
  endtask

  task automatic test_read();
    do_reset();
    bus_write(A_CTRL, 32'hFFFF_FF7D);
    bus_read(A_CTRL, 32'h71, 32'hFFFF_FFFF, "read ctrl");
    bus_read(A_BAD, 32'hA5A5_0001, 32'hFFFF_FFFF, "read unmapped");
    bus_write(A_PER, 32'hDEAD_1234);
    bus_read(A_PER, 32'h1234, 32'hFFFF_FFFF, "read period shadow");
    bus_read(A_ST, 32'h1, 32'h1, "read pend set");
    @(negedge clk);
    dma_io_radr = A_CTRL;
    dma_io_rdata_in = 32'h1234_5678;
    @(negedge clk);
    tests_run++;
    if (dma_io_rdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL read idle passthrough: got %h expected %h", dma_io_rdata, 32'h1234_5678);
    end
    dma_io_rdata_in = 32'hA5A5_0001;
  endtask

  task automatic test_inv_reset();
    int wraps = 0;
    do_reset();
    bus_write(A_CTRL, 32'h02);
    @(negedge clk);
    tests_run++;
    if (pwm_out !== 3'b111) begin
      fails++;
      $display("FAIL inv idle: got %b expected 111", pwm_out);
    end
    bus_write(A_PER, 32'd9);
    bus_write(A_D0, 32'd3);
    bus_write(A_CTRL, 32'h03);
    wait_wrap("inv first wrap");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    dma_io_we = 1'b1;
    dma_io_wadr = A_D1;
    dma_io_wdata = 32'h55;
    @(negedge clk);
    rst = 1'b0;
    dma_io_we = 1'b0;
    tests_run++;
    if (pwm_out !== 3'b000 || pwm_wrap !== 1'b0) begin
      fails++;
      $display("FAIL mid reset outputs: got %b/%b expected 000/0", pwm_out, pwm_wrap);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pwm_wrap) wraps++;
    end
    tests_run++;
    if (wraps != 0) begin
      fails++;
      $display("FAIL mid reset wraps: got %0d expected 0", wraps);
    end
    bus_read(A_CTRL, 32'h0, 32'hFFFF_FFFF, "mid reset ctrl");
    bus_read(A_PER, 32'h0000_FFFF, 32'hFFFF_FFFF, "mid reset period");
    bus_read(A_D0, 32'h0, 32'hFFFF_FFFF, "mid reset duty0");
    bus_read(A_D1, 32'h0, 32'hFFFF_FFFF, "reset-cycle write dropped");
    bus_read(A_ST, 32'h0, 32'hFFFF_FFFF, "mid reset status");
  endtask

  task automatic test_wrap_write();
    do_reset();
    bus_write(A_PER, 32'd9);
    bus_write(A_D2, 32'd2);
    bus_write(A_CTRL, 32'h01);
    wait_wrap("wrapwr first wrap");
    check_period(10, 2, 2, 9, A_D2, 32'd5, 0, 1'b0, "wrapwr before");
    check_period(10, 2, 2, 0, A_CTRL, 0, 3, 1'b1, "wrapwr held");
    check_period(10, 2, 5, 0, A_CTRL, 0, 0, 1'b0, "wrapwr applied");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_presc();
    test_shadow();
    test_read();
    test_inv_reset();
    test_wrap_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/io_pwm.md
IO_PWM -- requirements
Module: io_pwm

Interface
REQ-001 Parameter: PWM_BASE, default 14'h3E00 (word address, i.e. byte 0xF800), word address of the first register.
REQ-002 Parameter: NCH, default 3, number of PWM channels; fixed at 3 for this revision.
REQ-003 Port: clk, input, 1, sole clock; all state changes on the rising edge.
REQ-004 Port: rst, input, 1, reset; synchronous and active-high.
REQ-005 Port: dma_io_we, input, 1, IO bus write strobe; one write per asserted cycle.
REQ-006 Port: dma_io_wadr, input, 14 ([15:2]), IO bus write word address.
REQ-007 Port: dma_io_wdata, input, 32, IO bus write data.
REQ-008 Port: dma_io_radr, input, 14 ([15:2]), IO bus read word address.
REQ-009 Port: dma_io_radr_en, input, 1, IO bus read strobe.
REQ-010 Port: dma_io_rdata_in, input, 32, read data from the previous IO device in the chain.
REQ-011 Port: dma_io_rdata, output, 32, read data to the next device in the chain.
REQ-012 Port: pwm_out, output, 3, PWM waveforms; bit i is channel i, intended to drive rgb_led[2:0].
REQ-013 Port: pwm_wrap, output, 1, one-cycle pulse at each period wrap.

Function
REQ-014 Register map (offset from PWM_BASE, in words):
- +0 CTRL (R/W): [0] EN, [1] INV, [7:4] PRESC.
- +1 PERIOD (R/W): [15:0].
- +2..+4 DUTY0..DUTY2 (R/W): [15:0].
- +5 STATUS (RO): [0] PEND, [31:16] CNT.
- Unused bits read 0.
REQ-015 A write is taken on a cycle where dma_io_we=1 and dma_io_wadr matches a register. Writes to STATUS or to unmapped addresses are ignored.
REQ-016 Read is a one-stage pipeline:
- On a cycle with dma_io_radr_en=1 and a matching address, the hit flag and register value are captured.
- On the next cycle dma_io_rdata equals the captured value.
- In all other cycles dma_io_rdata equals dma_io_rdata_in, combinationally.
REQ-017 Prescaler: a 4-bit counter generates tick=1 once every PRESC+1 clk cycles while EN=1. PRESC=0 gives a tick every cycle.
REQ-018 Period counter: 16-bit CNT advances only on tick.
- When CNT==PERIOD_act, CNT wraps to 0; otherwise CNT increments.
- PERIOD_act=0 gives a 1-tick period (CNT stays 0).
REQ-019 Shadow registers: writes to PERIOD and DUTYi update shadow copies only and set PEND=1.
- Shadows are copied to the active copies at a tick where CNT==PERIOD_act, or on any cycle where EN=0.
- PEND clears in the same cycle as the copy.
REQ-020 A write to a shadow register in the same cycle as a copy sets PEND=1 and holds the new shadow value. The active copy receives the pre-write shadow value, and the new value transfers at the next copy.
REQ-021 Reads of PERIOD and DUTYi return the shadow values.
REQ-022 Output: pwm_out[i] = (CNT < DUTYi_act) XOR INV, registered, so it lags CNT by one cycle.
- DUTYi_act=0 holds the channel inactive.
- DUTYi_act > PERIOD_act holds it constantly active.
REQ-023 pwm_wrap is 1 for exactly one cycle following each tick at which CNT wraps from PERIOD_act to 0. It is never asserted while EN=0.
REQ-024 When EN=0:
- The prescaler and CNT are held at 0.
- pwm_out = {3{INV}}.
- CTRL writes take effect on the next cycle.
REQ-025 When EN changes from 0 to 1, counting starts from CNT=0 and the prescaler at 0 with the freshly copied active values. The first tick occurs PRESC+1 cycles later.
REQ-026 Changing PRESC while EN=1 takes effect immediately. If the prescaler count is at or above the new PRESC, it restarts at 0 on the next cycle.

Reset
REQ-027 When rst=1 at a clk edge, the following clear:
- CTRL=0; PERIOD shadow and active = 16'hFFFF; DUTY shadows and actives = 0.
- CNT=0, prescaler=0, PEND=0.
- pwm_out=3'b000, pwm_wrap=0, captured read hit=0.
REQ-028 Reset asserted mid-period aborts the cycle with no wrap pulse. A bus write in the same cycle as rst=1 is discarded.

Verification
REQ-029 Set PERIOD=9, DUTY0=3, CTRL=0x01 -> pwm_out[0] is high for 3 of every 10 cycles and pwm_wrap pulses every 10 cycles.
REQ-030 Set PRESC=3, PERIOD=4, DUTY1=5, then EN=1 -> pwm_out[1] is constantly high, pwm_wrap pulses every 20 cycles, and CNT reads 0..4.
REQ-031 While running with PERIOD=9, write DUTY0=7 at CNT=2 -> STATUS.PEND=1 and the waveform keeps a duty of 3 until the wrap. The next period has a duty of 7, and PEND=0 after the wrap.
REQ-032 Read CTRL at PWM_BASE, then read an unmapped address with dma_io_rdata_in=32'hA5A5_0001 -> the first read returns the CTRL value one cycle later; the second passes through 32'hA5A5_0001.
REQ-033 With INV=1 and EN=0 -> pwm_out=3'b111. Then assert rst for one cycle mid-period -> all registers return to reset values, pwm_out=0, and no pwm_wrap occurs.
REQ-034 A DUTY2 write in the exact wrap cycle -> the new value becomes active at the following wrap, not the current one.
